seg_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller that replaces the fixed 4-digit combinational decimal conversion and free-running scan used on the board today. It accepts a binary value with a LOAD strobe and converts it to BCD serially with shift-add-3 (one bit per cycle), or displays it as hex. The committed digits are time-multiplexed onto shared active-low segment and anode lines. It sits between the CPU's debug register output and the board display pins.

---
 rtl/seg_display_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: serial shift-add-3 binary-to-BCD (or direct hex)
// conversion, committed digits time-multiplexed onto active-low segment/anode lines.
module seg_display_ctrl #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  VALUE,
  input  logic              LOAD,
  input  logic              HEX,
  input  logic              BLANK_LZ,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVF,
  output logic [6:0]        SSEG,
  output logic [DIGITS-1:0] AN
);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2} state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'h0:    seg_encode = 7'b1000000;
      4'h1:    seg_encode = 7'b1111001;
      4'h2:    seg_encode = 7'b0100100;
      4'h3:    seg_encode = 7'b0110000;
      4'h4:    seg_encode = 7'b0011001;
      4'h5:    seg_encode = 7'b0010010;
      4'h6:    seg_encode = 7'b0000010;
      4'h7:    seg_encode = 7'b1111000;
      4'h8:    seg_encode = 7'b0000000;
      4'h9:    seg_encode = 7'b0010000;
      4'hA:    seg_encode = 7'b0001000;
      4'hB:    seg_encode = 7'b0000011;
      4'hC:    seg_encode = 7'b1000110;
      4'hD:    seg_encode = 7'b0100001;
      4'hE:    seg_encode = 7'b0000110;
      default: seg_encode = 7'b0001110;
    endcase
  endfunction

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;
  state_t            state_r, state_nx_s;
  logic [WIDTH-1:0]  val_r;
  logic              hex_r, blz_r;
  logic [DW-1:0]     bcd_r, bcd_adj_s;
  logic              ovf_acc_r;
  logic [CW-1:0]     cnt_r;
  logic [DW-1:0]     digits_r, commit_digits_s, disp_digits_s;
  logic [DIGITS-1:0] blank_r, blank_nx_s, disp_blank_s;
  logic              ovf_r, commit_ovf_s, disp_ovf_s, hex_ovf_s;
  logic              zero_above_s, commit_s, load_ok_s;
  logic              done_r, busy_r;
  logic [RW-1:0]     ref_cnt_r;
  logic              wrap_s;
  logic [IW-1:0]     idx_r, idx_nx_s;
  logic [3:0]        cur_digit_s;
  logic [6:0]        sseg_r, sseg_nx_s;
  logic [DIGITS-1:0] an_r, an_nx_s;

  // Reset synchroniser: asserts asynchronously, releases two clocks later.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rst_sync_r <= 2'b00;
    else      rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // A load is refused during the DONE cycle so each result is seen before the next starts.
  assign load_ok_s = LOAD & ~done_r;
  assign commit_s  = (state_r == COMMIT);

  // FSM state register.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) state_r <= IDLE;
    else          state_r <= state_nx_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_ok_s) state_nx_s = HEX ? COMMIT : SHIFT;
        else           state_nx_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == CW'(1)) state_nx_s = COMMIT;
        else                 state_nx_s = SHIFT;
      end
      COMMIT:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble ahead of the shift.
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[i*4 +: 4] >= 4'd5) bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
      else                         bcd_adj_s[i*4 +: 4] = bcd_r[i*4 +: 4];
    end
  end

  // Capture on load, then shift {bcd, value} left once per SHIFT cycle.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      val_r     <= '0;
      hex_r     <= 1'b0;
      blz_r     <= 1'b0;
      bcd_r     <= '0;
      ovf_acc_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_ok_s) begin
            val_r     <= VALUE;
            hex_r     <= HEX;
            blz_r     <= BLANK_LZ;
            bcd_r     <= '0;
            ovf_acc_r <= 1'b0;
            cnt_r     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          bcd_r     <= {bcd_adj_s[DW-2:0], val_r[WIDTH-1]};
          val_r     <= val_r << 1'b1;
          ovf_acc_r <= ovf_acc_r | bcd_adj_s[DW-1];
          cnt_r     <= cnt_r - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Commit values: hex digits come straight from the captured value, zero-extended.
  always_comb begin
    hex_ovf_s    = |(val_r >> DW);
    zero_above_s = 1'b1;
    blank_nx_s   = '0;
    if (hex_r) begin
      commit_digits_s = DW'(val_r);
      commit_ovf_s    = hex_ovf_s;
    end else begin
      commit_digits_s = bcd_r;
      commit_ovf_s    = ovf_acc_r;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above_s  = zero_above_s & (commit_digits_s[i*4 +: 4] == 4'd0);
      blank_nx_s[i] = blz_r & zero_above_s & (i != 0);
    end
  end

  // Committed display state and handshake outputs.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      digits_r <= '0;
      blank_r  <= '0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (commit_s) begin
        digits_r <= commit_digits_s;
        blank_r  <= blank_nx_s;
        ovf_r    <= commit_ovf_s;
      end
      done_r <= commit_s;
      busy_r <= (state_nx_s != IDLE);
    end
  end

  // Scan: next index and the segment pattern it will show, including a same-edge commit.
  always_comb begin
    wrap_s = (ref_cnt_r == RW'(REFRESH_DIV - 1));
    if (!wrap_s)                        idx_nx_s = idx_r;
    else if (idx_r == IW'(DIGITS - 1))  idx_nx_s = '0;
    else                                idx_nx_s = idx_r + IW'(1);
    if (commit_s) begin
      disp_digits_s = commit_digits_s;
      disp_blank_s  = blank_nx_s;
      disp_ovf_s    = commit_ovf_s;
    end else begin
      disp_digits_s = digits_r;
      disp_blank_s  = blank_r;
      disp_ovf_s    = ovf_r;
    end
    cur_digit_s = disp_digits_s[{idx_nx_s, 2'b00} +: 4];
    if (disp_ovf_s)                  sseg_nx_s = 7'b0111111;
    else if (disp_blank_s[idx_nx_s]) sseg_nx_s = 7'b1111111;
    else                             sseg_nx_s = seg_encode(cur_digit_s);
    for (int i = 0; i < DIGITS; i++) an_nx_s[i] = (idx_nx_s != IW'(i));
  end

  // Refresh counter, scan index and registered display pins.
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      ref_cnt_r <= '0;
      idx_r     <= '0;
      sseg_r    <= 7'b1000000;
      an_r      <= '1;
      an_r[0]   <= 1'b0;
    end else begin
      ref_cnt_r <= wrap_s ? '0 : ref_cnt_r + RW'(1);
      idx_r     <= idx_nx_s;
      sseg_r    <= sseg_nx_s;
      an_r      <= an_nx_s;
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign OVF  = ovf_r;
  assign SSEG = sseg_r;
  assign AN   = an_r;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Scoreboard bench for seg_display_ctrl: default 4-digit instance plus a 6-digit/20-bit
// instance with a short refresh period for randomized conversions.
module tb_seg_display_ctrl;
  localparam int RDIV0 = 1000;
  localparam int RDIV1 = 3;

  typedef struct packed {
    logic [55:0] segs;
    logic        ovf;
    logic [31:0] done_edge;
    logic [31:0] lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] val0;
  logic [19:0] val1;
  logic        load0, load1, hex_i, blz_i;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [6:0]  sseg0, sseg1;
  logic [3:0]  an0;
  logic [5:0]  an1;
  logic        sel;
  logic        m_done, m_busy, m_ovf;
  logic [6:0]  m_sseg;
  logic [7:0]  m_an;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   next_ok = 0;
  logic mon_busy = 1'b0;
  exp_t exp_q[$];

  seg_display_ctrl #(.DIGITS(4), .WIDTH(16), .REFRESH_DIV(RDIV0)) dut0 (
    .CLK(CLK), .RST(RST), .VALUE(val0), .LOAD(load0), .HEX(hex_i), .BLANK_LZ(blz_i),
    .BUSY(busy0), .DONE(done0), .OVF(ovf0), .SSEG(sseg0), .AN(an0));

  seg_display_ctrl #(.DIGITS(6), .WIDTH(20), .REFRESH_DIV(RDIV1)) dut1 (
    .CLK(CLK), .RST(RST), .VALUE(val1), .LOAD(load1), .HEX(hex_i), .BLANK_LZ(blz_i),
    .BUSY(busy1), .DONE(done1), .OVF(ovf1), .SSEG(sseg1), .AN(an1));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign m_done = sel ? done1 : done0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_ovf  = sel ? ovf1  : ovf0;
  assign m_sseg = sel ? sseg1 : sseg0;
  assign m_an   = sel ? {2'b11, an1} : {4'b1111, an0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;   3: return 7'b0110000;
      4: return 7'b0011001;   5: return 7'b0010010;   6: return 7'b0000010;   7: return 7'b1111000;
      8: return 7'b0000000;   9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Reference: digits by division, overflow/blanking by comparing against powers of the base.
  function automatic exp_t model_expect(input longint unsigned v, input bit hx, input bit bz,
                                        input int nd, input int k, input int width);
    exp_t e;
    longint unsigned base, pw, lim;
    int d;
    base = hx ? 64'd16 : 64'd10;
    lim = 64'd1;
    for (int i = 0; i < nd; i++) lim = lim * base;
    e.ovf  = (v >= lim);
    e.segs = {56{1'b1}};
    pw = 64'd1;
    for (int i = 0; i < nd; i++) begin
      d = int'((v / pw) % base);
      if (e.ovf)                      e.segs[i*7 +: 7] = 7'b0111111;
      else if (bz && i > 0 && v < pw) e.segs[i*7 +: 7] = 7'b1111111;
      else                            e.segs[i*7 +: 7] = seg_of(d);
      pw = pw * base;
    end
    e.lat       = hx ? 32'd1 : 32'(width + 1);
    e.done_edge = 32'(k) + e.lat;
    return e;
  endfunction

  task automatic issue_load(input logic [31:0] v, input bit hx, input bit bz);
    int k, w, nd;
    longint unsigned vv;
    exp_t e;
    @(negedge CLK);
    k = cyc + 1;
    hex_i = hx;
    blz_i = bz;
    if (sel) begin
      val1 = v[19:0]; load1 = 1'b1; vv = longint'(v[19:0]); w = 20; nd = 6;
    end else begin
      val0 = v[15:0]; load0 = 1'b1; vv = longint'(v[15:0]); w = 16; nd = 4;
    end
    if (k >= next_ok) begin
      e = model_expect(vv, hx, bz, nd, k, w);
      exp_q.push_back(e);
      next_ok = k + int'(e.lat) + 2;
    end
    @(negedge CLK);
    load0 = 1'b0;
    load1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || mon_busy) && t < budget) begin
      @(negedge CLK);
      t++;
    end
    check("idle_within_budget", (t < budget) ? 64'd1 : 64'd0, 64'd1);
  endtask

  // Monitor: pops an expectation on every DONE, then checks a full scan of the display.
  initial begin : monitor
    exp_t e;
    int nd, rdiv, busy_run, run, zeros, idx, extra, an_bad;
    bit have_chg;
    logic [7:0] an_prev, seen, bad;
    logic [6:0] badv [8];
    logic [6:0] want;
    busy_run = 0;
    forever begin
      @(negedge CLK);
      if (m_done === 1'b1) begin
        check("done_has_expectation", (exp_q.size() > 0) ? 64'd1 : 64'd0, 64'd1);
        if (exp_q.size() > 0) begin
          mon_busy = 1'b1;
          e = exp_q.pop_front();
          nd   = sel ? 6 : 4;
          rdiv = sel ? RDIV1 : RDIV0;
          check("done_edge", cyc, e.done_edge);
          check("busy_cycles", busy_run, e.lat);
          check("busy_low_at_done", m_busy, 1'b0);
          check("ovf", m_ovf, e.ovf);
          seen = '0; bad = '0; extra = 0; an_bad = 0; have_chg = 1'b0; run = 0;
          an_prev = m_an;
          for (int c = 0; c < nd * rdiv; c++) begin
            if (c != 0) begin
              @(negedge CLK);
              if (m_done === 1'b1) extra++;
            end
            zeros = 0; idx = 0;
            for (int i = 0; i < 8; i++) if (m_an[i] === 1'b0) begin zeros++; idx = i; end
            if (zeros != 1 || idx >= nd) an_bad++;
            else begin
              seen[idx] = 1'b1;
              if (m_sseg !== e.segs[idx*7 +: 7] && !bad[idx]) begin
                bad[idx]  = 1'b1;
                badv[idx] = m_sseg;
              end
            end
            if (c != 0) begin
              if (m_an !== an_prev) begin
                if (have_chg) check("scan_period", run, rdiv);
                have_chg = 1'b1;
                run = 1;
              end else run++;
            end
            an_prev = m_an;
          end
          check("an_onehot_errors", an_bad, 0);
          check("extra_done", extra, 0);
          for (int i = 0; i < nd; i++) begin
            want = e.segs[i*7 +: 7];
            check($sformatf("digit%0d_scanned", i), seen[i], 1'b1);
            check($sformatf("digit%0d_sseg", i), bad[i] ? badv[i] : want, want);
          end
          busy_run = 0;
          mon_busy = 1'b0;
        end
      end else if (m_busy === 1'b1) busy_run++;
      else busy_run = 0;
    end
  end

  initial begin : stimulus
    int n, lat;
    logic [31:0] v;
    bit hx, bz;
    RST = 1'b0; load0 = 1'b0; load1 = 1'b0; val0 = '0; val1 = '0;
    hex_i = 1'b0; blz_i = 1'b0; sel = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (1500) @(negedge CLK);
    check("scan_moved_before_reset", an0, 4'b1101);

    // Reset mid-scan must take effect without a clock edge.
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("rst_an", an0, 4'b1110);
    check("rst_sseg", sseg0, 7'b1000000);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_ovf", ovf0, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    n = 0;
    while (an0[1] !== 1'b0 && n < 1100) begin
      @(negedge CLK);
      n++;
    end
    // Release passes through the two-flop synchroniser before the refresh count starts.
    check_range("rst_release_first_advance", n, RDIV0, RDIV0 + 2);

    issue_load(32'd1234, 1'b0, 1'b0);  wait_idle(6000);
    issue_load(32'd65535, 1'b0, 1'b0); wait_idle(6000);

    // Reset during a conversion: no DONE, digits and OVF back to zero.
    issue_load(32'd1234, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    next_ok = 0;
    #1;
    check("abort_busy", busy0, 1'b0);
    check("abort_ovf_cleared", ovf0, 1'b0);
    check("abort_sseg", sseg0, 7'b1000000);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    check("abort_an_after", an0, 4'b1110);
    check("abort_sseg_after", sseg0, 7'b1000000);

    issue_load(32'd9999, 1'b0, 1'b0);  wait_idle(6000);
    issue_load(32'h00A5, 1'b1, 1'b1);  wait_idle(6000);
    issue_load(32'd0, 1'b0, 1'b1);     wait_idle(6000);
    issue_load(32'd42, 1'b0, 1'b0);
    repeat (1) @(negedge CLK);
    issue_load(32'd77, 1'b0, 1'b0);
    wait_idle(6000);

    sel = 1'b1;
    next_ok = 0;
    issue_load(32'd999999, 1'b0, 1'b0); wait_idle(500);
    for (int r = 0; r < 25; r++) begin
      v  = $urandom() & 32'h000F_FFFF;
      v  = v >> $urandom_range(0, 19);
      hx = 1'($urandom_range(0, 1));
      bz = 1'($urandom_range(0, 1));
      issue_load(v, hx, bz);
      if ($urandom_range(0, 2) == 0) begin
        lat = hx ? 1 : 21;
        repeat ($urandom_range(0, lat - 1)) @(negedge CLK);
        issue_load($urandom() & 32'h000F_FFFF, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_idle(500);
    end
    repeat (30) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
